acc_ctrl: RTL and testbench

- Sequencer for the 16-entry accumulator buffer (20-bit partial sums per lane, saturated 8-bit read-out, one-cycle registered read).
- Runs a job in two phases:
  - ACCUM: steers the systolic-array partial-sum stream into accumulator rows. The first pass overwrites rows; later passes accumulate.
  - DRAIN: reads rows out in order with valid/ready backpressure toward the unified buffer.
- Sits between the top-level controller (start/done) and the accumulator's wea/acc_en/addra/enb/addrb pins.

---
 rtl/acc_ctrl.sv | 178 +++++++++++++++++
 tb/tb_acc_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_ctrl.sv
// acc_ctrl: accumulator-buffer sequencer (ACCUM overwrite/accumulate passes, then DRAIN with valid/ready).
// Optional stall counter enabled by defining ACC_CTRL_PERF_CNT_EN; otherwise stall_cnt is tied to 0.
module acc_ctrl #(
  parameter int RAM_DEPTH = 16,
  parameter int ADDR_W    = 4,
  parameter int PASS_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   cfg_rows,
  input  logic [PASS_W-1:0] cfg_passes,
  input  logic              psum_valid,
  input  logic              out_ready,
  output logic              wea,
  output logic              acc_en,
  output logic [ADDR_W-1:0] addra,
  output logic              enb,
  output logic [ADDR_W-1:0] addrb,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_FINISH} state_t;

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(RAM_DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   rows_q, rows_d;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic [ADDR_W:0]   wr_row_q, wr_row_d;
  logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [ADDR_W:0]   rd_row_q, rd_row_d;
  logic              out_valid_q, out_valid_d;
  logic              cfg_err_q, cfg_err_d;
  logic              cfg_ok;
  logic              issue;
  logic              last_row;
  logic              last_pass;

  assign cfg_ok    = (cfg_rows != '0) && (cfg_rows <= DEPTH) && (cfg_passes != '0);
  assign last_row  = (wr_row_q == rows_q - 1'b1);
  assign last_pass = (pass_cnt_q == passes_q - 1'b1);

  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    passes_d    = passes_q;
    wr_row_d    = wr_row_q;
    pass_cnt_d  = pass_cnt_q;
    rd_row_d    = rd_row_q;
    out_valid_d = out_valid_q;
    cfg_err_d   = 1'b0;
    issue       = 1'b0;
    wea         = 1'b0;
    acc_en      = 1'b0;
    addra       = '0;
    enb         = 1'b0;
    addrb       = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            rows_d      = cfg_rows;
            passes_d    = cfg_passes;
            wr_row_d    = '0;
            pass_cnt_d  = '0;
            rd_row_d    = '0;
            out_valid_d = 1'b0;
            state_d     = S_ACCUM;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      S_ACCUM: begin
        // Write strobes are combinational so they line up with the psum row on dina.
        wea    = psum_valid;
        addra  = wr_row_q[ADDR_W-1:0];
        acc_en = (pass_cnt_q != '0);
        if (psum_valid) begin
          if (last_row) begin
            wr_row_d   = '0;
            pass_cnt_d = pass_cnt_q + 1'b1;
            if (last_pass) begin
              rd_row_d = '0;
              state_d  = S_DRAIN;
            end
          end else begin
            wr_row_d = wr_row_q + 1'b1;
          end
        end
      end

      S_DRAIN: begin
        // Only refill the read register when it is empty or being consumed, so doutb holds on a stall.
        issue = (rd_row_q < rows_q) && (!out_valid_q || out_ready);
        enb   = issue;
        addrb = rd_row_q[ADDR_W-1:0];
        if (issue) begin
          rd_row_d    = rd_row_q + 1'b1;
          out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
        if ((rd_row_q == rows_q) && out_valid_q && out_ready) begin
          state_d = S_FINISH;
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rows_q      <= '0;
      passes_q    <= '0;
      wr_row_q    <= '0;
      pass_cnt_q  <= '0;
      rd_row_q    <= '0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      passes_q    <= passes_d;
      wr_row_q    <= wr_row_d;
      pass_cnt_q  <= pass_cnt_d;
      rd_row_q    <= rd_row_d;
      out_valid_q <= out_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign cfg_err   = cfg_err_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FINISH);

`ifdef ACC_CTRL_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == S_IDLE) && start && cfg_ok) begin
      stall_cnt_d = '0;
    end else if ((state_q == S_DRAIN) && out_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_acc_ctrl.sv
// Bench for acc_ctrl: behavioural accumulator RAM, row-sum reference model, queue scoreboard.
module tb_acc_ctrl;
  localparam int RAM_DEPTH = 16;
  localparam int ADDR_W    = 4;
  localparam int PASS_W    = 8;
`ifdef ACC_CTRL_PERF_CNT_EN
  localparam int STALL_EN = 1;
`else
  localparam int STALL_EN = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   cfg_rows = '0;
  logic [PASS_W-1:0] cfg_passes = '0;
  logic              psum_valid = 1'b0;
  logic              out_ready = 1'b0;
  logic              wea, acc_en, enb, out_valid, busy, done, cfg_err;
  logic [ADDR_W-1:0] addra, addrb;
  logic [15:0]       stall_cnt;

  acc_ctrl #(.RAM_DEPTH(RAM_DEPTH), .ADDR_W(ADDR_W), .PASS_W(PASS_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_rows(cfg_rows), .cfg_passes(cfg_passes),
    .psum_valid(psum_valid), .out_ready(out_ready), .wea(wea), .acc_en(acc_en), .addra(addra),
    .enb(enb), .addrb(addrb), .out_valid(out_valid), .busy(busy), .done(done),
    .cfg_err(cfg_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Accumulator RAM stand-in driven by the DUT's control pins.
  logic [19:0]       dina = '0;
  logic [19:0]       doutb = '0;
  logic [ADDR_W-1:0] rd_addr_q = '0;
  logic [19:0]       mem [RAM_DEPTH];
  always @(posedge clk) begin
    if (wea) mem[addra] <= acc_en ? mem[addra] + dina : dina;
    if (enb) begin
      doutb     <= mem[addrb];
      rd_addr_q <= addrb;
    end
  end

  typedef struct { int addr; int acc; } wr_t;
  typedef struct { int row; int val; } rd_t;
  wr_t wr_q[$];
  rd_t rd_q[$];
  int  sums [RAM_DEPTH];
  int  acc_count = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;
  int  last_acc_cyc = 0;
  int  job_t0 = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT writes or hands off a row.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wea) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("addra", int'(addra), w.addr);
          chk("acc_en", int'(acc_en), w.acc);
        end
      end
      if (out_valid && out_ready) begin
        if (rd_q.size() == 0) begin
          chk("unexpected_row", 1, 0);
        end else begin
          rd_t r;
          r = rd_q.pop_front();
          chk("drain_row", int'(rd_addr_q), r.row);
          chk("drain_data", int'(doutb), r.val);
        end
        acc_count++;
        last_acc_cyc = cyc;
      end
      if (out_valid && !out_ready) chk("enb_during_stall", int'(enb), 0);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a job and streams every psum row; the reference sums are plain per-row arithmetic.
  task automatic issue_job(input int rows, input int passes, input int gap_mode, input int noise);
    int v;
    for (int r = 0; r < RAM_DEPTH; r++) sums[r] = 0;
    acc_count  = 0;
    cfg_rows   = (ADDR_W+1)'(rows);
    cfg_passes = PASS_W'(passes);
    start      = 1'b1;
    job_t0     = cyc;
    step();
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    for (int p = 0; p < passes; p++) begin
      for (int r = 0; r < rows; r++) begin
        if ((gap_mode == 1 && !(p == 0 && r == 0)) || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
          psum_valid = 1'b0;
          dina       = 20'($urandom_range(0, 1000));
          start      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
          cfg_rows   = noise ? (ADDR_W+1)'($urandom_range(1, 16)) : cfg_rows;
          step();
        end
        v          = $urandom_range(0, 1000);
        dina       = 20'(v);
        psum_valid = 1'b1;
        start      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        sums[r]    = (p == 0) ? v : sums[r] + v;
        wr_q.push_back('{r, (p != 0) ? 1 : 0});
        step();
      end
    end
    start      = 1'b0;
    psum_valid = 1'b0;
    for (int r = 0; r < rows; r++) rd_q.push_back('{r, sums[r]});
  endtask

  task automatic run_job(input int rows, input int passes, input int gap_mode,
                         input int stall, input int rnd_ready, input int noise);
    int d0;
    int budget;
    d0 = done_cnt;
    out_ready = stall ? 1'b0 : 1'b1;
    issue_job(rows, passes, gap_mode, noise);
    if (stall) begin
      budget = 0;
      while (!out_valid && budget < 50) begin
        step();
        budget++;
      end
      repeat (5) @(posedge clk);
      #1;
      out_ready = 1'b1;
    end
    budget = 0;
    while (acc_count < rows && budget < 1000) begin
      out_ready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      psum_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      dina       = 20'($urandom_range(0, 1000));
      step();
      budget++;
    end
    psum_valid = 1'b0;
    out_ready  = 1'b1;
    chk("rows_drained", acc_count, rows);
    for (int i = 0; i < 6 && done_cnt == d0; i++) step();
    chk("done_pulses", done_cnt - d0, 1);
    chk("done_after_last_accept", done_cyc - last_acc_cyc, 1);
    if (gap_mode == 0 && stall == 0 && rnd_ready == 0)
      chk("job_length", done_cyc - job_t0, rows * passes + rows + 2);
    chk("busy_after_done", int'(busy), 0);
    chk("done_single", int'(done), 0);
    if (stall) chk("stall_cnt", int'(stall_cnt), STALL_EN ? 5 : 0);
    else if (rnd_ready == 0) chk("stall_cnt_zero", int'(stall_cnt), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
  endtask

  task automatic bad_cfg(input int rows, input int passes);
    psum_valid = 1'b1;
    cfg_rows   = (ADDR_W+1)'(rows);
    cfg_passes = PASS_W'(passes);
    start      = 1'b1;
    step();
    start = 1'b0;
    chk("cfg_err_pulse", int'(cfg_err), 1);
    chk("cfg_err_busy", int'(busy), 0);
    chk("cfg_err_wea", int'(wea), 0);
    step();
    chk("cfg_err_clear", int'(cfg_err), 0);
    chk("cfg_err_idle", int'(busy), 0);
    psum_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wea"}, int'(wea), 0);
    chk({tag, "_acc_en"}, int'(acc_en), 0);
    chk({tag, "_addra"}, int'(addra), 0);
    chk({tag, "_enb"}, int'(enb), 0);
    chk({tag, "_addrb"}, int'(addrb), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_cfg_err"}, int'(cfg_err), 0);
    chk({tag, "_stall_cnt"}, int'(stall_cnt), 0);
  endtask

  initial begin
    int d0;
    int budget;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();

    run_job(16, 1, 0, 0, 0, 0);
    run_job(4, 3, 1, 0, 0, 0);
    run_job(4, 1, 0, 1, 0, 0);

    bad_cfg(0, 1);
    bad_cfg(17, 1);
    bad_cfg(4, 0);

    // Reset in the middle of DRAIN, after two rows have been accepted.
    d0 = done_cnt;
    out_ready = 1'b1;
    issue_job(8, 1, 0, 0);
    budget = 0;
    while (acc_count < 2 && budget < 50) begin
      step();
      budget++;
    end
    chk("mid_drain_rows", acc_count, 2);
    rst_n = 1'b0;
    step();
    chk_all_zero("mid_reset");
    rst_n = 1'b1;
    wr_q.delete();
    rd_q.delete();
    step();
    step();
    chk("no_done_after_reset", done_cnt - d0, 0);

    run_job(3, 2, 0, 0, 0, 0);
    run_job(5, 2, 2, 0, 0, 1);
    for (int j = 0; j < 5; j++)
      run_job($urandom_range(1, 16), $urandom_range(1, 4), 2, 0, 1, j % 2);
    run_job(1, 1, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not complete (cycle %0d)", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
